ddr_req_arbiter: RTL and testbench

DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

---
 rtl/ddr_req_arbiter.sv | 130 +++++++++++++
 tb/tb_ddr_req_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: round-robin arbiter between fetch bursts and load/store accesses onto one DDR port
module ddr_req_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 512,
  parameter int TMO_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fe_req_valid,
  input  logic [ADDR_W-1:0]  fe_req_addr,
  output logic               fe_req_ready,
  output logic               fe_resp_valid,
  output logic [BURST_W-1:0] fe_resp_data,
  input  logic               ls_req_valid,
  input  logic               ls_req_write,
  input  logic [ADDR_W-1:0]  ls_req_addr,
  input  logic [DATA_W-1:0]  ls_req_wdata,
  input  logic [DATA_W-1:0]  ls_req_wmask,
  output logic               ls_req_ready,
  output logic               ls_resp_valid,
  output logic [DATA_W-1:0]  ls_resp_rdata,
  output logic               ddr_chip_enable,
  output logic               ddr_write_enable,
  output logic               ddr_burst_mode,
  output logic [ADDR_W-1:0]  ddr_address,
  output logic [DATA_W-1:0]  ddr_write_mask,
  output logic [DATA_W-1:0]  ddr_write_data,
  input  logic [BURST_W-1:0] ddr_burst_read,
  input  logic [DATA_W-1:0]  ddr_read_data,
  input  logic               ddr_ready,
  output logic               tmo_err
);
  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] TMO = CW'(TMO_CYC);
  localparam logic [1:0] IDLE = 2'd0, FE_BUSY = 2'd1, LS_BUSY = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d, wmask_q, wmask_d;
  logic               fe_resp_valid_q, fe_resp_valid_d, ls_resp_valid_q, ls_resp_valid_d;
  logic [BURST_W-1:0] fe_resp_data_q, fe_resp_data_d;
  logic [DATA_W-1:0]  ls_resp_rdata_q, ls_resp_rdata_d;
  logic [CW-1:0]      wdog_q, wdog_d;
  logic               tmo_err_q, tmo_err_d;
  logic               last_fe_q, last_fe_d;
  logic               idle, fe_busy, ls_busy, fe_grant, ls_grant;
  assign idle     = state_q == IDLE;
  assign fe_busy  = state_q == FE_BUSY;
  assign ls_busy  = state_q == LS_BUSY;
  assign fe_grant = rst_n && idle && fe_req_valid && (!ls_req_valid || !last_fe_q);
  assign ls_grant = rst_n && idle && ls_req_valid && !fe_grant;
  assign fe_req_ready     = fe_grant;
  assign ls_req_ready     = ls_grant;
  assign fe_resp_valid    = fe_resp_valid_q;
  assign fe_resp_data     = fe_resp_data_q;
  assign ls_resp_valid    = ls_resp_valid_q;
  assign ls_resp_rdata    = ls_resp_rdata_q;
  assign tmo_err          = tmo_err_q;
  assign ddr_chip_enable  = fe_busy || ls_busy;
  assign ddr_burst_mode   = fe_busy;
  assign ddr_write_enable = ls_busy && write_q;
  assign ddr_address      = (fe_busy || ls_busy) ? addr_q : '0;
  assign ddr_write_mask   = ls_busy ? wmask_q : '0;
  assign ddr_write_data   = ls_busy ? wdata_q : '0;
  // Accept a request in IDLE, complete it on ddr_ready, or abandon it when the watchdog expires
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    write_d         = write_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    fe_resp_valid_d = 1'b0;
    ls_resp_valid_d = 1'b0;
    fe_resp_data_d  = fe_resp_data_q;
    ls_resp_rdata_d = ls_resp_rdata_q;
    wdog_d          = wdog_q;
    tmo_err_d       = tmo_err_q;
    last_fe_d       = last_fe_q;
    if (fe_grant || ls_grant) begin
      state_d   = fe_grant ? FE_BUSY : LS_BUSY;
      addr_d    = fe_grant ? fe_req_addr : ls_req_addr;
      write_d   = ls_grant && ls_req_write;
      wdata_d   = ls_req_wdata;
      wmask_d   = ls_req_wmask;
      wdog_d    = '0;
      last_fe_d = fe_grant;
    end else if (!idle && ddr_ready) begin
      state_d         = IDLE;
      fe_resp_valid_d = fe_busy;
      ls_resp_valid_d = ls_busy;
      fe_resp_data_d  = fe_busy ? ddr_burst_read : fe_resp_data_q;
      ls_resp_rdata_d = ls_busy ? (write_q ? '0 : ddr_read_data) : ls_resp_rdata_q;
    end else if (!idle) begin
      wdog_d    = (wdog_q == TMO) ? wdog_q : wdog_q + 1'b1;
      state_d   = (wdog_d == TMO) ? IDLE : state_q;
      tmo_err_d = tmo_err_q || (wdog_d == TMO);
    end
  end
  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      write_q         <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      fe_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      fe_resp_data_q  <= '0;
      ls_resp_rdata_q <= '0;
      wdog_q          <= '0;
      tmo_err_q       <= 1'b0;
      last_fe_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      write_q         <= write_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      fe_resp_valid_q <= fe_resp_valid_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      fe_resp_data_q  <= fe_resp_data_d;
      ls_resp_rdata_q <= ls_resp_rdata_d;
      wdog_q          <= wdog_d;
      tmo_err_q       <= tmo_err_d;
      last_fe_q       <= last_fe_d;
    end
  end
endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: directed scoreboard bench for ddr_req_arbiter
module tb_ddr_req_arbiter;
  localparam int AW = 64, DW = 64, BW = 512, TMO = 1024;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst_n, fe_req_valid, fe_req_ready, fe_resp_valid;
  logic [AW-1:0] fe_req_addr, ls_req_addr, ddr_address;
  logic [BW-1:0] fe_resp_data, ddr_burst_read;
  logic          ls_req_valid, ls_req_write, ls_req_ready, ls_resp_valid;
  logic [DW-1:0] ls_req_wdata, ls_req_wmask, ls_resp_rdata, ddr_write_mask, ddr_write_data, ddr_read_data;
  logic          ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_ready, tmo_err;
  ddr_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fe_req_valid(fe_req_valid), .fe_req_addr(fe_req_addr), .fe_req_ready(fe_req_ready),
    .fe_resp_valid(fe_resp_valid), .fe_resp_data(fe_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_write(ls_req_write), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
    .ddr_chip_enable(ddr_chip_enable), .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_address(ddr_address), .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
    .ddr_burst_read(ddr_burst_read), .ddr_read_data(ddr_read_data), .ddr_ready(ddr_ready),
    .tmo_err(tmo_err)
  );
  typedef struct { logic fe; logic [BW-1:0] data; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [BW-1:0] mkpat(input int base);
    logic [BW-1:0] p;
    for (int i = 0; i < 8; i++) p[i*64 +: 64] = 64'(base + i);
    return p;
  endfunction
  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    chk("ready_excl", BW'(fe_req_ready & ls_req_ready), '0);
    if (fe_resp_valid || ls_resp_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: fe=%0b ls=%0b want no pulse", fe_resp_valid, ls_resp_valid);
      end else begin
        e = q.pop_front();
        chk("resp_port", BW'(fe_resp_valid), BW'(e.fe));
        chk("resp_both", BW'(fe_resp_valid & ls_resp_valid), '0);
        chk("resp_data", e.fe ? fe_resp_data : BW'(ls_resp_rdata), e.data);
      end
    end
  end
  task automatic fe_txn(input logic [AW-1:0] a, input logic [BW-1:0] pat, input int lat);
    @(posedge clk); #1; fe_req_valid = 1'b1; fe_req_addr = a;
    @(negedge clk);
    chk("fe_ready", BW'(fe_req_ready), BW'(1'b1));
    chk("fe_ls_ready", BW'(ls_req_ready), '0);
    q.push_back(exp_t'{1'b1, pat});
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      fe_req_valid = 1'b0; fe_req_addr = '1;
      ddr_ready = (k == lat); ddr_burst_read = (k == lat) ? pat : '1;
      @(negedge clk);
      chk("fe_ce", BW'(ddr_chip_enable), BW'(1'b1));
      chk("fe_burst", BW'(ddr_burst_mode), BW'(1'b1));
      chk("fe_we", BW'(ddr_write_enable), '0);
      chk("fe_addr", BW'(ddr_address), BW'(a));
      chk("fe_mask", BW'(ddr_write_mask), '0);
      chk("fe_wdata", BW'(ddr_write_data), '0);
      chk("fe_busy_ready", BW'(fe_req_ready | ls_req_ready), '0);
    end
    @(posedge clk); #1; ddr_ready = 1'b0; ddr_burst_read = '1;
    @(negedge clk);
    chk("fe_pulse", BW'(fe_resp_valid), BW'(1'b1));
    chk("fe_idle_ce", BW'(ddr_chip_enable), '0);
  endtask
  task automatic ls_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, input logic [DW-1:0] rd, input int lat);
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_write = wr; ls_req_addr = a; ls_req_wdata = wd; ls_req_wmask = wm;
    @(negedge clk);
    chk("ls_ready", BW'(ls_req_ready), BW'(1'b1));
    chk("ls_fe_ready", BW'(fe_req_ready), '0);
    q.push_back(exp_t'{1'b0, BW'(wr ? '0 : rd)});
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      ls_req_valid = 1'b0; ls_req_write = ~wr; ls_req_addr = '1; ls_req_wdata = '1; ls_req_wmask = '0;
      ddr_ready = (k == lat); ddr_read_data = (k == lat) ? rd : '1;
      @(negedge clk);
      chk("ls_ce", BW'(ddr_chip_enable), BW'(1'b1));
      chk("ls_burst", BW'(ddr_burst_mode), '0);
      chk("ls_we", BW'(ddr_write_enable), BW'(wr));
      chk("ls_addr", BW'(ddr_address), BW'(a));
      chk("ls_mask", BW'(ddr_write_mask), BW'(wm));
      chk("ls_wdata", BW'(ddr_write_data), BW'(wd));
    end
    @(posedge clk); #1; ddr_ready = 1'b0; ddr_read_data = '1;
    @(negedge clk);
    chk("ls_pulse", BW'(ls_resp_valid), BW'(1'b1));
    chk("ls_idle_ce", BW'(ddr_chip_enable), '0);
  endtask
  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    rst_n = 1'b0; fe_req_valid = 1'b1; fe_req_addr = '0; ls_req_valid = 1'b1; ls_req_write = 1'b0;
    ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
    ddr_burst_read = '1; ddr_read_data = '1; ddr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fe_ready", BW'(fe_req_ready), '0);
    chk("rst_ls_ready", BW'(ls_req_ready), '0);
    chk("rst_ce", BW'(ddr_chip_enable), '0);
    chk("rst_addr", BW'(ddr_address), '0);
    chk("rst_tmo", BW'(tmo_err), '0);
    chk("rst_fe_data", fe_resp_data, '0);
    chk("rst_ls_data", BW'(ls_resp_rdata), '0);
    @(posedge clk); #1;
    rst_n = 1'b1; fe_req_valid = 1'b0; ls_req_valid = 1'b0; ddr_ready = 1'b0;
    fe_txn(64'h1000, mkpat(0), 3);
    ls_txn(1'b1, 64'h20, 64'hDEAD, '1, 64'h5555, 2);
    chk("fe_data_hold", fe_resp_data, mkpat(0));
    ls_txn(1'b0, 64'h20, 64'h0, 64'h0, 64'hDEAD, 2);
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
      fe_req_valid = 1'b1; fe_req_addr = 64'h3000; ls_req_valid = 1'b1; ls_req_write = 1'b0; ddr_ready = 1'b0;
      @(negedge clk);
      chk("arb_fe_ready", BW'(fe_req_ready), BW'(g % 2 == 0));
      chk("arb_ls_ready", BW'(ls_req_ready), BW'(g % 2 == 1));
      q.push_back(exp_t'{(g % 2 == 0), (g % 2 == 0) ? mkpat(100 + 8 * g) : BW'(64'('hA000 + g))});
      @(posedge clk); #1;
      ddr_ready = 1'b1; ddr_burst_read = mkpat(100 + 8 * g); ddr_read_data = 64'('hA000 + g);
      if (g == 3) begin fe_req_valid = 1'b0; ls_req_valid = 1'b0; end
      @(negedge clk);
      chk("arb_burst", BW'(ddr_burst_mode), BW'(g % 2 == 0));
    end
    @(posedge clk); #1; ddr_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; fe_req_valid = 1'b1; fe_req_addr = 64'h2000;
    @(negedge clk);
    chk("tmo_fe_ready", BW'(fe_req_ready), BW'(1'b1));
    n = 0;
    for (int k = 0; k < TMO + 10; k++) begin
      @(posedge clk); #1; fe_req_valid = 1'b0;
      @(negedge clk);
      if (!ddr_chip_enable) break;
      n++;
    end
    chk("tmo_cycles", BW'(n), BW'(TMO));
    chk("tmo_err_set", BW'(tmo_err), BW'(1'b1));
    @(posedge clk); #1; ddr_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; ddr_ready = 1'b0;
    chk("idle_ready_ignored_ce", BW'(ddr_chip_enable), '0);
    ls_txn(1'b0, 64'h80, 64'h0, 64'h0, 64'h1234_5678, 1);
    chk("tmo_sticky", BW'(tmo_err), BW'(1'b1));
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_write = 1'b1; ls_req_addr = 64'h40; ls_req_wdata = 64'hBEEF; ls_req_wmask = '1;
    @(negedge clk);
    chk("rstmid_ls_ready", BW'(ls_req_ready), BW'(1'b1));
    @(posedge clk); #1; ls_req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_we", BW'(ddr_write_enable), BW'(1'b1));
    @(posedge clk); #1; rst_n = 1'b0; ddr_ready = 1'b1; fe_req_valid = 1'b1; ls_req_valid = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_gated", BW'(fe_req_ready | ls_req_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_ce", BW'(ddr_chip_enable), '0);
    chk("rstmid_we0", BW'(ddr_write_enable), '0);
    chk("rstmid_addr", BW'(ddr_address), '0);
    chk("rstmid_mask", BW'(ddr_write_mask), '0);
    chk("rstmid_data", BW'(ddr_write_data), '0);
    chk("rstmid_resp", BW'(fe_resp_valid | ls_resp_valid), '0);
    chk("rstmid_fe_data", fe_resp_data, '0);
    chk("rstmid_ls_data", BW'(ls_resp_rdata), '0);
    chk("rstmid_tmo", BW'(tmo_err), '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fe_ready", BW'(fe_req_ready), BW'(1'b1));
    chk("post_rst_ls_ready", BW'(ls_req_ready), '0);
    chk("post_rst_ce", BW'(ddr_chip_enable), '0);
    @(posedge clk); #1; fe_req_valid = 1'b0; ls_req_valid = 1'b0; ddr_ready = 1'b0;
    q.push_back(exp_t'{1'b1, mkpat(200)});
    @(negedge clk);
    chk("post_rst_burst", BW'(ddr_burst_mode), BW'(1'b1));
    @(posedge clk); #1; ddr_ready = 1'b1; ddr_burst_read = mkpat(200);
    @(posedge clk); #1; ddr_ready = 1'b0; ddr_burst_read = '1;
    @(negedge clk);
    chk("post_rst_pulse", BW'(fe_resp_valid), BW'(1'b1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", BW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
